seat_timer_bank: RTL and testbench

SEAT_TIMER_BANK -- requirements
Module: seat_timer_bank

---
 rtl/seat_timer_bank.sv | 182 ++++++++++++++++++
 tb/tb_seat_timer_bank.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/seat_timer_bank.sv
// Bank of per-seat minute countdown timers sharing one wall clock, with a
// command port for seat control and a one-at-a-time expiry presentation port.
`timescale 1ns/1ps
module seat_timer_bank #(
    parameter int N_SEATS       = 8,
    parameter int TICKS_PER_MIN = 60,
    parameter int CNT_W         = 8,
    parameter int WARN_MIN      = 10,
    localparam int SEL_W        = $clog2(N_SEATS)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [SEL_W-1:0]   cmd_seat,
    input  logic [CNT_W-1:0]   cmd_minutes,
    output logic               cmd_err,
    output logic [10:0]        time_out,
    output logic [N_SEATS-1:0] seat_busy,
    output logic [N_SEATS-1:0] seat_warn,
    output logic               expire_valid,
    output logic [SEL_W-1:0]   expire_seat,
    input  logic               expire_ready
);
    localparam int PRE_W = $clog2(TICKS_PER_MIN);
    localparam logic [1:0] OP_START   = 2'b00;
    localparam logic [1:0] OP_EXTEND  = 2'b01;
    localparam logic [1:0] OP_RELEASE = 2'b10;

    typedef enum logic [1:0] {IDLE = 2'd0, ACTIVE = 2'd1, EXPIRED = 2'd2} seat_state_e;

    logic [PRE_W-1:0]   presc_q;
    logic [5:0]         min_q;
    logic [4:0]         hour_q;
    logic               rdy_q;
    seat_state_e        state_q [N_SEATS];
    seat_state_e        state_d [N_SEATS];
    logic [CNT_W-1:0]   rem_q   [N_SEATS];
    logic [CNT_W-1:0]   rem_d   [N_SEATS];
    logic [N_SEATS-1:0] busy_q, busy_d, warn_q, warn_d;
    logic               err_q, err_d;
    logic               exp_valid_q, exp_valid_d;
    logic [SEL_W-1:0]   exp_seat_q, exp_seat_d;
    logic               min_tick, cmd_fire, seat_ok, found;
    logic [SEL_W-1:0]   first_exp;
    logic [CNT_W:0]     ext_sum;

    // Commands are refused on tick cycles, so a command never races a decrement.
    assign min_tick  = (presc_q == PRE_W'(TICKS_PER_MIN - 1));
    assign cmd_ready = rdy_q & ~min_tick;
    assign cmd_fire  = cmd_valid & cmd_ready;
    assign seat_ok   = (32'(cmd_seat) < 32'(N_SEATS));

    assign time_out     = {hour_q, min_q};
    assign seat_busy    = busy_q;
    assign seat_warn    = warn_q;
    assign cmd_err      = err_q;
    assign expire_valid = exp_valid_q;
    assign expire_seat  = exp_seat_q;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q <= '0;
            min_q   <= '0;
            hour_q  <= '0;
            rdy_q   <= 1'b0;
        end else begin
            rdy_q <= 1'b1;
            if (min_tick) begin
                presc_q <= '0;
                if (min_q == 6'd59) begin
                    min_q  <= '0;
                    hour_q <= (hour_q == 5'd23) ? 5'd0 : hour_q + 5'd1;
                end else begin
                    min_q <= min_q + 6'd1;
                end
            end else begin
                presc_q <= presc_q + PRE_W'(1);
            end
        end
    end

    // Lowest-index expired seat; nothing is presented while this is consulted.
    always_comb begin
        found     = 1'b0;
        first_exp = '0;
        for (int i = N_SEATS - 1; i >= 0; i--) begin
            if (state_q[i] == EXPIRED) begin
                found     = 1'b1;
                first_exp = SEL_W'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_SEATS; i++) begin
            busy_d[i] = (state_q[i] != IDLE);
            warn_d[i] = (state_q[i] == ACTIVE) && (32'(rem_q[i]) <= 32'(WARN_MIN));
        end
    end

    // NOTE: defaults first in every always_comb so no path infers a latch.
    always_comb begin
        state_d     = state_q;
        rem_d       = rem_q;
        err_d       = 1'b0;
        exp_valid_d = exp_valid_q;
        exp_seat_d  = exp_seat_q;
        ext_sum     = '0;

        if (min_tick) begin
            for (int i = 0; i < N_SEATS; i++) begin
                if (state_q[i] == ACTIVE) begin
                    rem_d[i] = rem_q[i] - CNT_W'(1);
                    if (rem_q[i] == CNT_W'(1)) state_d[i] = EXPIRED;
                end
            end
        end

        if (exp_valid_q && expire_ready) begin
            state_d[exp_seat_q] = IDLE;
            exp_valid_d         = 1'b0;
        end else if (!exp_valid_q && found) begin
            exp_valid_d = 1'b1;
            exp_seat_d  = first_exp;
        end

        if (cmd_fire) begin
            if (!seat_ok) begin
                err_d = 1'b1;
            end else begin
                unique case (cmd_op)
                    OP_START: begin
                        if (state_q[cmd_seat] == IDLE && cmd_minutes != '0) begin
                            state_d[cmd_seat] = ACTIVE;
                            rem_d[cmd_seat]   = cmd_minutes;
                        end else err_d = 1'b1;
                    end
                    OP_EXTEND: begin
                        if (state_q[cmd_seat] == ACTIVE) begin
                            ext_sum         = {1'b0, rem_q[cmd_seat]} + {1'b0, cmd_minutes};
                            rem_d[cmd_seat] = ext_sum[CNT_W] ? '1 : ext_sum[CNT_W-1:0];
                        end else err_d = 1'b1;
                    end
                    OP_RELEASE: begin
                        if (state_q[cmd_seat] == ACTIVE) begin
                            state_d[cmd_seat] = IDLE;
                            rem_d[cmd_seat]   = '0;
                        end else err_d = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: the seat arrays are reset explicitly; reset must idle every seat at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_SEATS; i++) begin
                state_q[i] <= IDLE;
                rem_q[i]   <= '0;
            end
            busy_q      <= '0;
            warn_q      <= '0;
            err_q       <= 1'b0;
            exp_valid_q <= 1'b0;
            exp_seat_q  <= '0;
        end else begin
            state_q     <= state_d;
            rem_q       <= rem_d;
            busy_q      <= busy_d;
            warn_q      <= warn_d;
            err_q       <= err_d;
            exp_valid_q <= exp_valid_d;
            exp_seat_q  <= exp_seat_d;
        end
    end

endmodule

// File: tb/tb_seat_timer_bank.sv
// Directed bench for seat_timer_bank with a small configuration; expected
// expiries are queued at stimulus time and popped as the DUT presents them.
`timescale 1ns/1ps
module tb_seat_timer_bank;
    localparam int NS  = 4;
    localparam int TPM = 4;
    localparam int CW  = 4;
    localparam int WM  = 2;
    localparam int SW  = 2;

    localparam logic [1:0] START   = 2'b00;
    localparam logic [1:0] EXTEND  = 2'b01;
    localparam logic [1:0] RELEASE = 2'b10;
    localparam logic [1:0] NOP     = 2'b11;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic [1:0]    cmd_op = NOP;
    logic [SW-1:0] cmd_seat = '0;
    logic [CW-1:0] cmd_minutes = '0;
    logic          cmd_err;
    logic [10:0]   time_out;
    logic [NS-1:0] seat_busy, seat_warn;
    logic          expire_valid;
    logic [SW-1:0] expire_seat;
    logic          expire_ready = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int edges;
    int exp_q[$];

    seat_timer_bank #(
        .N_SEATS(NS), .TICKS_PER_MIN(TPM), .CNT_W(CW), .WARN_MIN(WM)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_seat(cmd_seat), .cmd_minutes(cmd_minutes), .cmd_err(cmd_err),
        .time_out(time_out), .seat_busy(seat_busy), .seat_warn(seat_warn),
        .expire_valid(expire_valid), .expire_seat(expire_seat),
        .expire_ready(expire_ready)
    );

    always #5 clk = ~clk;

    // Edges since reset release: the reference for prescaler phase and wall time.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    function automatic logic [10:0] exp_time(input int e);
        int m;
        m = (e / TPM) % 1440;
        return {5'(m / 60), 6'(m % 60)};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input int seat, input int mins,
                          input logic exp_err, input string tag);
        int g;
        g = 0;
        while (cmd_ready !== 1'b1 && g < 8) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_ready"}, 32'(cmd_ready), 32'd1);
        cmd_valid   = 1'b1;
        cmd_op      = op;
        cmd_seat    = SW'(seat);
        cmd_minutes = CW'(mins);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        check({tag, "_err"}, 32'(cmd_err), 32'(exp_err));
    endtask

    task automatic wait_ticks(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            while (edges % TPM != 0) @(negedge clk);
        end
        @(negedge clk);
    endtask

    task automatic wait_expiry(input string tag);
        int g;
        int want;
        g = 0;
        while (expire_valid !== 1'b1 && g < 40) begin
            @(negedge clk);
            g++;
        end
        check({tag, "_valid"}, 32'(expire_valid), 32'd1);
        want = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
        check({tag, "_seat"}, 32'(expire_seat), 32'(want));
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check("rst_time",  32'(time_out),     32'd0);
        check("rst_busy",  32'(seat_busy),    32'd0);
        check("rst_warn",  32'(seat_warn),    32'd0);
        check("rst_valid", 32'(expire_valid), 32'd0);
        check("rst_seat",  32'(expire_seat),  32'd0);
        check("rst_err",   32'(cmd_err),      32'd0);
        check("rst_ready", 32'(cmd_ready),    32'd0);
        rst_n = 1'b1;
        check("ready_pre_edge", 32'(cmd_ready), 32'd0);

        // Full day walk of the wall clock
        for (int k = 0; k < 1440 * TPM; k++) begin
            @(negedge clk);
            check("walk_time",  32'(time_out),  32'(exp_time(edges)));
            check("walk_ready", 32'(cmd_ready), (edges % TPM == TPM - 1) ? 32'd0 : 32'd1);
        end
        check("time_wrap", 32'(time_out), 32'd0);

        // Seat 2 for 3 minutes: warning, expiry, release on transfer
        expire_ready = 1'b1;
        do_cmd(START, 2, 3, 1'b0, "start2");
        exp_q.push_back(2);
        @(negedge clk);
        check("busy2", 32'(seat_busy), 32'b0100);
        check("nowarn2", 32'(seat_warn), 32'b0000);
        wait_ticks(1);
        check("warn2", 32'(seat_warn), 32'b0100);
        wait_expiry("exp2");
        @(negedge clk);
        check("exp2_drop", 32'(expire_valid), 32'd0);
        @(negedge clk);
        check("busy2_clr", 32'(seat_busy), 32'd0);

        // Illegal commands and NOP
        do_cmd(EXTEND, 0, 3, 1'b1, "ext_idle");
        @(negedge clk);
        check("err_pulse", 32'(cmd_err), 32'd0);
        do_cmd(RELEASE, 0, 0, 1'b1, "rel_idle");
        do_cmd(START, 0, 0, 1'b1, "start_zero");
        do_cmd(NOP, 0, 0, 1'b0, "nop");
        check("nop_busy", 32'(seat_busy), 32'd0);

        // Saturating extend: 14 + 5 clips to 15
        do_cmd(START, 1, 14, 1'b0, "start1");
        do_cmd(EXTEND, 1, 5, 1'b0, "ext1");
        do_cmd(START, 1, 2, 1'b1, "start_active");
        wait_ticks(12);
        check("sat_busy", 32'(seat_busy), 32'b0010);
        check("sat_hi",   32'(seat_warn), 32'b0000);
        wait_ticks(1);
        check("sat_warn", 32'(seat_warn), 32'b0010);
        do_cmd(RELEASE, 1, 0, 1'b0, "rel1");
        @(negedge clk);
        check("rel1_busy", 32'(seat_busy), 32'd0);
        check("rel1_warn", 32'(seat_warn), 32'd0);

        // Seats 3 and 0 expire on the same tick; presented ascending, held stable
        expire_ready = 1'b0;
        while (edges % TPM != 0) @(negedge clk);
        do_cmd(START, 3, 1, 1'b0, "start3");
        do_cmd(START, 0, 1, 1'b0, "start0");
        exp_q.push_back(0);
        exp_q.push_back(3);
        wait_expiry("exp0");
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_valid", 32'(expire_valid), 32'd1);
            check("hold_seat",  32'(expire_seat),  32'd0);
        end
        expire_ready = 1'b1;
        @(negedge clk);
        check("gap", 32'(expire_valid), 32'd0);
        wait_expiry("exp3");
        @(negedge clk);
        check("exp3_drop", 32'(expire_valid), 32'd0);
        @(negedge clk);
        check("dual_busy", 32'(seat_busy), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        // Command held across a min_tick cycle is taken exactly once, afterwards
        while (edges % TPM != TPM - 1) @(negedge clk);
        check("ready_tick", 32'(cmd_ready), 32'd0);
        cmd_valid   = 1'b1;
        cmd_op      = START;
        cmd_seat    = 2'd0;
        cmd_minutes = 4'd5;
        @(negedge clk);
        check("ready_after_tick", 32'(cmd_ready), 32'd1);
        check("tick_no_busy", 32'(seat_busy), 32'd0);
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = NOP;
        check("single_accept", 32'(cmd_err), 32'd0);
        @(negedge clk);
        check("late_busy", 32'(seat_busy), 32'b0001);

        // Reset while an expiry is presented
        expire_ready = 1'b0;
        do_cmd(START, 1, 1, 1'b0, "start1b");
        exp_q.push_back(1);
        wait_expiry("exp1b");
        #2 rst_n = 1'b0;
        #1;
        check("mid_time",  32'(time_out),     32'd0);
        check("mid_busy",  32'(seat_busy),    32'd0);
        check("mid_warn",  32'(seat_warn),    32'd0);
        check("mid_valid", 32'(expire_valid), 32'd0);
        check("mid_seat",  32'(expire_seat),  32'd0);
        check("mid_err",   32'(cmd_err),      32'd0);
        check("mid_ready", 32'(cmd_ready),    32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        expire_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check("post_valid", 32'(expire_valid), 32'd0);
            check("post_busy",  32'(seat_busy),    32'd0);
        end
        check("post_time", 32'(time_out), 32'(exp_time(edges)));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
